// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register command sequencer: command opcodes
// and FSM states.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_LOAD_SHL = 2'b01,
        OP_LOAD_SHR = 2'b10,
        OP_SHL      = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } seq_state_e;

    // Ops that start with a parallel load of cmd_data and then shift it.
    function automatic logic op_load_then_shift(input cmd_op_e op);
        return (op == OP_LOAD_SHL) || (op == OP_LOAD_SHR);
    endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter that sets the number of SHIFT cycles. It flags
// "last" when one cycle remains and "zero" when it holds no count at all.
module shift_seq_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic             last,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Sequences one command into load/shift pulses for a universal shift register.
// It samples the resulting q and returns it on a response channel.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] d,
    output logic             load,
    output logic             shiftLeft,
    output logic             shiftRight,
    input  logic [WIDTH-1:0] q_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A valid source holds its payload stable until that edge, and ready
    // never depends combinationally on valid.

    seq_state_e state;
    cmd_op_e    op_q;
    logic       accept;
    logic       cnt_last;
    logic       cnt_zero;
    logic       cnt_dec;

    assign accept  = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign cnt_dec = (state == S_SHIFT) && !cnt_last;

    shift_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .ld     (accept),
        .ld_val (cmd_count),
        .dec    (cnt_dec),
        .last   (cnt_last),
        .zero   (cnt_zero)
    );

    // Outputs are registered alongside the state, so each control takes the
    // value that belongs to the state being entered on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_LOAD;
            cmd_ready  <= 1'b0;
            d          <= '0;
            load       <= 1'b0;
            shiftLeft  <= 1'b0;
            shiftRight <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready  <= 1'b1;
                    d          <= '0;
                    load       <= 1'b0;
                    shiftLeft  <= 1'b0;
                    shiftRight <= 1'b0;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op_e'(cmd_op);
                        if (cmd_op_e'(cmd_op) == OP_SHL) begin
                            if (cmd_count == '0) begin
                                state <= S_CAPTURE;
                            end else begin
                                state     <= S_SHIFT;
                                shiftLeft <= 1'b1;
                            end
                        end else begin
                            state <= S_LOAD;
                            load  <= 1'b1;
                            d     <= cmd_data;
                        end
                    end
                end
                S_LOAD: begin
                    load <= 1'b0;
                    d    <= '0;
                    if (op_load_then_shift(op_q) && !cnt_zero) begin
                        state      <= S_SHIFT;
                        shiftLeft  <= (op_q == OP_LOAD_SHL);
                        shiftRight <= (op_q == OP_LOAD_SHR);
                    end else begin
                        state <= S_CAPTURE;
                    end
                end
                S_SHIFT: begin
                    if (cnt_last) begin
                        state      <= S_CAPTURE;
                        shiftLeft  <= 1'b0;
                        shiftRight <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    rsp_data  <= q_in;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    cmd_ready  <= 1'b0;
                    d          <= '0;
                    load       <= 1'b0;
                    shiftLeft  <= 1'b0;
                    shiftRight <= 1'b0;
                    rsp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: models the downstream 4-bit shift register and
// checks responses, pulse counts and latency against a command-level model.
module tb_shift_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_count;
    logic [3:0] d;
    logic       load;
    logic       shiftLeft;
    logic       shiftRight;
    logic [3:0] q_in;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] reg_exp;
    logic [3:0] q_reg;

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [2:0] cnt;
        int         delay;
        bit         poke;
        logic [3:0] exp_rsp;
        int         exp_lat;
    } vec_t;

    vec_t vecs[12];

    shift_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .d          (d),
        .load       (load),
        .shiftLeft  (shiftLeft),
        .shiftRight (shiftRight),
        .q_in       (q_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data)
    );

    // Clock and the downstream universal shift register.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset)           q_reg <= 4'b0000;
        else if (load)       q_reg <= d;
        else if (shiftLeft)  q_reg <= {q_reg[2:0], 1'b0};
        else if (shiftRight) q_reg <= {1'b0, q_reg[3:1]};
    end
    assign q_in = q_reg;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Command-level reference: what the register holds once the command ends.
    function automatic logic [3:0] model_rsp(input logic [1:0] op, input logic [3:0] data,
                                             input logic [2:0] cnt, input logic [3:0] q_before);
        int v;
        case (op)
            2'b00:   v = int'(data);
            2'b01:   v = (int'(data) << cnt) & 15;
            2'b10:   v = int'(data) >> cnt;
            default: v = (int'(q_before) << cnt) & 15;
        endcase
        return v[3:0];
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [2:0] cnt);
        if (op == 2'b00) return 3;
        if (op == 2'b11) return 2 + int'(cnt);
        return 3 + int'(cnt);
    endfunction

    // Issue one command at a negedge, watch its control pulses, then hold off
    // the response for 'delay' cycles before accepting it.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                           input int delay, input bit poke, input logic [3:0] exp_rsp,
                           input int exp_lat);
        int k, n_ld, n_sl, n_sr, e_ld, e_sl, e_sr;
        bit got, d_ok, onehot_ok, busy_ok;
        logic [3:0] held, e;
        chk("cmd_ready_idle", int'(cmd_ready), 1);
        exp_q.push_back(exp_rsp);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(0, 3)); cmd_data = 4'($urandom_range(0, 15));
        cmd_count = 3'($urandom_range(0, 7));
        k = 1; got = 0; n_ld = 0; n_sl = 0; n_sr = 0; d_ok = 1; onehot_ok = 1; busy_ok = 1;
        while (k <= 40 && !got) begin
            if (rsp_valid) begin
                got = 1;
            end else begin
                n_ld += int'(load); n_sl += int'(shiftLeft); n_sr += int'(shiftRight);
                if (int'(load) + int'(shiftLeft) + int'(shiftRight) > 1) onehot_ok = 0;
                if (load && d !== data) d_ok = 0;
                if (!load && d !== 4'b0000) d_ok = 0;
                if (cmd_ready) busy_ok = 0;
                cmd_valid = poke && (k == 1);
                @(negedge clk);
                k++;
            end
        end
        cmd_valid = 1'b0;
        e_ld = (op != 2'b11) ? 1 : 0;
        e_sl = (op == 2'b01 || op == 2'b11) ? int'(cnt) : 0;
        e_sr = (op == 2'b10) ? int'(cnt) : 0;
        chk("rsp_arrived", int'(got), 1);
        chk("latency", k, exp_lat);
        chk("load_pulses", n_ld, e_ld);
        chk("shl_pulses", n_sl, e_sl);
        chk("shr_pulses", n_sr, e_sr);
        chk("d_value", int'(d_ok), 1);
        chk("one_hot", int'(onehot_ok), 1);
        chk("cmd_ready_busy", int'(busy_ok), 1);
        e = exp_q.pop_front();
        chk("rsp_data", int'(rsp_data), int'(e));
        held = rsp_data;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("rsp_hold", int'({rsp_valid, cmd_ready, load | shiftLeft | shiftRight, rsp_data}),
                int'({1'b1, 1'b0, 1'b0, held}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_release", int'({rsp_valid, cmd_ready}), int'(2'b01));
    endtask

    initial begin
        vecs[0]  = '{2'b00, 4'b1010, 3'd3, 0, 1'b0, 4'b1010, 3};
        vecs[1]  = '{2'b01, 4'b0011, 3'd2, 0, 1'b0, 4'b1100, 5};
        vecs[2]  = '{2'b10, 4'b1011, 3'd1, 4, 1'b0, 4'b0101, 4};
        vecs[3]  = '{2'b00, 4'b1110, 3'd0, 1, 1'b0, 4'b1110, 3};
        vecs[4]  = '{2'b11, 4'b0000, 3'd0, 0, 1'b0, 4'b1110, 2};
        vecs[5]  = '{2'b11, 4'b1111, 3'd7, 2, 1'b0, 4'b0000, 9};
        vecs[6]  = '{2'b01, 4'b0101, 3'd0, 0, 1'b0, 4'b0101, 3};
        vecs[7]  = '{2'b10, 4'b1000, 3'd7, 0, 1'b0, 4'b0000, 10};
        vecs[8]  = '{2'b01, 4'b0001, 3'd3, 1, 1'b1, 4'b1000, 6};
        vecs[9]  = '{2'b00, 4'b0111, 3'd0, 0, 1'b0, 4'b0111, 3};
        vecs[10] = '{2'b11, 4'b0000, 3'd1, 0, 1'b1, 4'b1110, 3};
        vecs[11] = '{2'b10, 4'b1111, 3'd3, 3, 1'b1, 4'b0001, 6};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'b0000;
        cmd_count = 3'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({d, load, shiftLeft, shiftRight, rsp_valid, rsp_data}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'({cmd_ready, rsp_valid}), int'(2'b10));
        reg_exp = 4'b0000;

        // rsp_ready high while idle must not produce a response.
        rsp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_rsp_ready", int'({rsp_valid, cmd_ready}), int'(2'b01));
        end
        rsp_ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].delay, vecs[i].poke,
                    vecs[i].exp_rsp, vecs[i].exp_lat);
            reg_exp = vecs[i].exp_rsp;
        end

        // Reset in the middle of a LOAD_SHL by 5: everything drops, then recovers.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b0011; cmd_count = 3'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_shift_active", int'({load, shiftLeft, shiftRight}), int'(3'b010));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", int'({d, load, shiftLeft, shiftRight, rsp_valid, rsp_data}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_ready", int'({cmd_ready, rsp_valid}), int'(2'b10));
        reg_exp = 4'b0000;
        run_cmd(2'b00, 4'b0110, 3'd0, 0, 1'b0, 4'b0110, 3);
        reg_exp = 4'b0110;
        run_cmd(2'b11, 4'b0000, 3'd0, 0, 1'b0, 4'b0110, 2);

        // Randomized commands against the command-level model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [3:0] data, e;
            logic [2:0] cnt;
            op   = 2'($urandom_range(0, 3));
            data = 4'($urandom_range(0, 15));
            cnt  = 3'($urandom_range(0, 7));
            e    = model_rsp(op, data, cnt, reg_exp);
            if ($urandom_range(0, 3) == 0) begin
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                chk("idle_rsp_ready_rand", int'({rsp_valid, cmd_ready}), int'(2'b01));
            end
            run_cmd(op, data, cnt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), e,
                    model_lat(op, cnt));
            reg_exp = e;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
